sram_rr_arbiter: RTL
====================

Name: sram_rr_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for one 32x1024 single-port SRAM macro with active-low controls. It accepts valid/ready requests from two clients and grants one access per cycle. It drives the macro's registered-input port and returns read data to the issuing client with fixed latency. It sits between the macro and its two clients, for example a fetch engine and a DMA engine.

Parameters:
ADDR_WIDTH, 10, word address width
DATA_WIDTH, 32, data width
NUM_WMASKS, 4, byte lanes (DATA_WIDTH/8)

Ports:
clk0  in  1  clock; all sequential logic on the rising edge except the read-capture latch
reset  in  1  asynchronous, active-high reset
p0_valid / p1_valid  in  1  request valid
p0_ready / p1_ready  out  1  request accepted this cycle (combinational)
p0_we / p1_we  in  1  1=write, 0=read
p0_be / p1_be  in  NUM_WMASKS  active-high byte enables (writes only)
p0_addr / p1_addr  in  ADDR_WIDTH  word address
p0_wdata / p1_wdata  in  DATA_WIDTH  write data
p0_rvalid / p1_rvalid  out  1  one-cycle read-response pulse
p0_rdata / p1_rdata  out  DATA_WIDTH  read data; holds until the next response to that port
sram_csb0  out  1  macro chip select, active low
sram_web0  out  1  macro write enable, active low
sram_wmask0  out  NUM_WMASKS  macro byte mask, active low
sram_addr0  out  ADDR_WIDTH  macro address
sram_din0  out  DATA_WIDTH  macro write data
sram_dout0  in  DATA_WIDTH  macro read data; valid from the falling edge of the macro access cycle until the next rising edge

Behaviour:
- Reset values (asynchronous): sram_csb0=1, sram_web0=1, sram_wmask0=all 1, sram_addr0=0, sram_din0=0, pN_rvalid=0, pN_rdata=0, priority pointer=port 0, pipeline flags cleared.
- Grant (combinational):
  - Only one port valid: that port is granted.
  - Both valid: the port selected by the priority pointer is granted.
  - pN_ready = grant_N. At most one ready is high per cycle.
- Priority pointer: after each accepted request, it moves to the port that did not win. With no handshake it holds.
- Stage 1 (issue), at the rising edge after handshake edge E:
  - Register sram_csb0=0.
  - sram_web0 = ~we.
  - sram_addr0 = addr.
  - sram_din0 = wdata on writes, else hold.
  - sram_wmask0 = ~be on writes, all 1 on reads.
  - With no handshake: sram_csb0=1 and the other outputs hold.
  - Also register rd_flag = ~we and tag = granted port.
- Stage 2 (macro access, cycle after E+1):
  - The macro samples inputs at E+1 and reads or writes on that cycle's falling edge.
  - The capture latch is transparent while clk0 low and stage-2 rd_flag=1. It closes at the rising edge, so the macro's output invalidation at E+2 is not captured.
- Stage 3: at edge E+2, p[tag]_rdata is loaded from the latch and p[tag]_rvalid=1 for exactly one cycle.
  - Read latency: handshake at edge E, rvalid high in the cycle following edge E+2.
- Writes produce no response. A write with be=0 is still issued, with all mask bits 1, and modifies nothing.
- Throughput: one access per cycle sustained, no bubbles; back-to-back reads give back-to-back rvalid pulses.
- Read-after-write to the same address, issued in consecutive cycles, returns the new data. The write commits on the falling edge of its access cycle, one cycle before the read's access.
- Reset mid-operation clears all in-flight stages: no rvalid after reset deasserts, macro deselected immediately, pointer back to port 0.
- The pipeline has no backpressure; clients must accept rvalid unconditionally.

Test Plan:
- Reset, then p0 write addr=0x005, wdata=0xDEADBEEF, be=4'hF; then p0 read 0x005 -> p0_rvalid high 2 edges after the read handshake, p0_rdata=0xDEADBEEF, p1_rvalid stays 0.
- Partial write: preload 0x010=0x11223344; p1 write wdata=0xAABBCCDD, be=4'b0101, so sram_wmask0=4'b1010; read back -> 0x11BB33DD.
- Both ports read continuously for 6 cycles (p0 at 0x000, p1 at 0x001) -> grants alternate p0,p1,p0,p1…, one ready per cycle, each rvalid carrying the matching port's data.
- Single requester p1 streaming 8 reads of 0x100..0x107 -> ready every cycle, 8 consecutive p1_rvalid pulses with data in address order.
- Write 0x020=0x0000CAFE then read 0x020 on the next cycle -> rdata=0x0000CAFE.
- Assert reset between a read handshake and its response -> no rvalid afterwards, sram_csb0=1 during reset, first post-reset tie grants p0.

Source files
------------

// File: rtl/sram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// sram_rr_arbiter
//
// Two-client round-robin arbiter and access sequencer for a single-port
// 32x1024 SRAM macro with active-low, registered-input controls.
//
// Each cycle at most one valid/ready handshake is accepted. The accepted
// request is registered straight onto the macro port (issue stage). The macro
// samples it one edge later and performs the access on that cycle's falling
// edge (access stage). Read data is caught by a transparent-low latch and is
// handed back to the issuing client one edge after that (response stage).
//
// Ports
//   clk0                  clock; rising edge except the read-capture latch
//   reset                 asynchronous, active-high reset
//   pN_valid / pN_ready   request handshake (ready is combinational)
//   pN_we                 1 = write, 0 = read
//   pN_be                 active-high byte enables (writes only)
//   pN_addr / pN_wdata    word address and write data
//   pN_rvalid             one-cycle read-response pulse
//   pN_rdata              read data, held until the next response to port N
//   sram_csb0/web0        macro chip select / write enable, active low
//   sram_wmask0           macro byte mask, active low
//   sram_addr0/din0       macro address / write data
//   sram_dout0            macro read data (valid from falling edge of the
//                         access cycle until the next rising edge)
// ---------------------------------------------------------------------------
module sram_rr_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk0,
  input  logic                  reset,

  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic                  p0_we,
  input  logic [NUM_WMASKS-1:0] p0_be,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,

  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic                  p1_we,
  input  logic [NUM_WMASKS-1:0] p1_be,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,

  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  // Arbitration and selected request
  logic                  grant0_s;
  logic                  grant1_s;
  logic                  hs_s;
  logic                  sel_we_s;
  logic [NUM_WMASKS-1:0] sel_be_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;

  // Priority pointer: 0 = port 0 wins a tie, 1 = port 1 wins a tie
  logic                  ptr_q,         ptr_d;

  // Issue stage (these flops are the macro port)
  logic                  sram_csb0_q,   sram_csb0_d;
  logic                  sram_web0_q,   sram_web0_d;
  logic [NUM_WMASKS-1:0] sram_wmask0_q, sram_wmask0_d;
  logic [ADDR_WIDTH-1:0] sram_addr0_q,  sram_addr0_d;
  logic [DATA_WIDTH-1:0] sram_din0_q,   sram_din0_d;
  logic                  s1_rd_q,       s1_rd_d;
  logic                  s1_tag_q,      s1_tag_d;

  // Access stage
  logic                  s2_rd_q,       s2_rd_d;
  logic                  s2_tag_q,      s2_tag_d;

  // Response stage
  logic                  p0_rvalid_q,   p0_rvalid_d;
  logic                  p1_rvalid_q,   p1_rvalid_d;
  logic [DATA_WIDTH-1:0] p0_rdata_q,    p0_rdata_d;
  logic [DATA_WIDTH-1:0] p1_rdata_q,    p1_rdata_d;

  // Read-capture latch
  logic [DATA_WIDTH-1:0] cap_lat;

  // Grant: a lone requester always wins; on a tie the pointer decides.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (p0_valid && p1_valid) begin
      if (ptr_q) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b1;
      end
    end else if (p0_valid) begin
      grant0_s = 1'b1;
    end else if (p1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign hs_s     = grant0_s | grant1_s;
  assign p0_ready = grant0_s;
  assign p1_ready = grant1_s;

  // Request mux: port 1 fields only when port 1 holds the grant.
  always_comb begin
    if (grant1_s) begin
      sel_we_s    = p1_we;
      sel_be_s    = p1_be;
      sel_addr_s  = p1_addr;
      sel_wdata_s = p1_wdata;
    end else begin
      sel_we_s    = p0_we;
      sel_be_s    = p0_be;
      sel_addr_s  = p0_addr;
      sel_wdata_s = p0_wdata;
    end
  end

  // Next-state for pointer and issue stage.
  always_comb begin
    ptr_d         = ptr_q;
    sram_csb0_d   = 1'b1;
    sram_web0_d   = sram_web0_q;
    sram_wmask0_d = sram_wmask0_q;
    sram_addr0_d  = sram_addr0_q;
    sram_din0_d   = sram_din0_q;
    s1_rd_d       = 1'b0;
    s1_tag_d      = s1_tag_q;
    if (hs_s) begin
      // The loser of this handshake gets priority next time.
      ptr_d        = grant0_s;
      sram_csb0_d  = 1'b0;
      sram_web0_d  = ~sel_we_s;
      sram_addr0_d = sel_addr_s;
      s1_rd_d      = ~sel_we_s;
      s1_tag_d     = grant1_s;
      if (sel_we_s) begin
        // be=0 still issues; the all-ones mask makes it a no-op write.
        sram_wmask0_d = ~sel_be_s;
        sram_din0_d   = sel_wdata_s;
      end else begin
        sram_wmask0_d = {NUM_WMASKS{1'b1}};
        sram_din0_d   = sram_din0_q;
      end
    end else begin
      ptr_d       = ptr_q;
      sram_csb0_d = 1'b1;
    end
  end

  // Next-state for access and response stages.
  always_comb begin
    s2_rd_d     = s1_rd_q;
    s2_tag_d    = s1_tag_q;
    p0_rvalid_d = s2_rd_q & ~s2_tag_q;
    p1_rvalid_d = s2_rd_q &  s2_tag_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    if (p0_rvalid_d) begin
      p0_rdata_d = cap_lat;
    end else begin
      p0_rdata_d = p0_rdata_q;
    end
    if (p1_rvalid_d) begin
      p1_rdata_d = cap_lat;
    end else begin
      p1_rdata_d = p1_rdata_q;
    end
  end

  // Capture latch: open only in the low phase of a read access cycle, so it
  // closes on the rising edge before the macro invalidates its output.
  always_latch begin
    if (!clk0 && s2_rd_q) begin
      cap_lat = sram_dout0;
    end
  end

  // Pointer and issue-stage registers.
  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      ptr_q         <= 1'b0;
      sram_csb0_q   <= 1'b1;
      sram_web0_q   <= 1'b1;
      sram_wmask0_q <= {NUM_WMASKS{1'b1}};
      sram_addr0_q  <= {ADDR_WIDTH{1'b0}};
      sram_din0_q   <= {DATA_WIDTH{1'b0}};
      s1_rd_q       <= 1'b0;
      s1_tag_q      <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      sram_csb0_q   <= sram_csb0_d;
      sram_web0_q   <= sram_web0_d;
      sram_wmask0_q <= sram_wmask0_d;
      sram_addr0_q  <= sram_addr0_d;
      sram_din0_q   <= sram_din0_d;
      s1_rd_q       <= s1_rd_d;
      s1_tag_q      <= s1_tag_d;
    end
  end

  // Access-stage and response-stage registers.
  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      s2_rd_q     <= 1'b0;
      s2_tag_q    <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= {DATA_WIDTH{1'b0}};
      p1_rdata_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      s2_rd_q     <= s2_rd_d;
      s2_tag_q    <= s2_tag_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  assign sram_csb0   = sram_csb0_q;
  assign sram_web0   = sram_web0_q;
  assign sram_wmask0 = sram_wmask0_q;
  assign sram_addr0  = sram_addr0_q;
  assign sram_din0   = sram_din0_q;
  assign p0_rvalid   = p0_rvalid_q;
  assign p1_rvalid   = p1_rvalid_q;
  assign p0_rdata    = p0_rdata_q;
  assign p1_rdata    = p1_rdata_q;

endmodule
